// File: rtl/k_and_s_pkg.sv
// K-and-S shared types: instruction decode, control states, ALU opcodes, flags.
// branch_taken() resolves conditional branches from the registered flags.
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP, I_LOAD, I_STORE, I_MOVE,
      I_ADD, I_SUB, I_AND, I_OR,
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
      I_BNNEG, I_BOV, I_BNOV, I_HALT
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_LOAD_ADDR,
      S_LOAD_WB, S_STORE, S_MOVE, S_ALU,
      S_BRANCH, S_NEXT, S_HALT
   } ctrl_state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef struct packed {
      logic zero;
      logic neg;
      logic uov;
      logic sov;
   } flags_t;

   function automatic logic branch_taken(
      decoded_instruction_type ins,
      flags_t                  f
   );
      logic t;
      case (ins)
         I_BRANCH: t = 1'b1;
         I_BZERO:  t = f.zero;
         I_BNZERO: t = ~f.zero;
         I_BNEG:   t = f.neg;
         I_BNNEG:  t = ~f.neg;
         I_BOV:    t = f.uov;
         I_BNOV:   t = ~f.uov;
         default:  t = 1'b0;
      endcase
      return t;
   endfunction

   function automatic logic [1:0] alu_op(decoded_instruction_type ins);
      logic [1:0] op;
      case (ins)
         I_SUB:   op = ALU_SUB;
         I_AND:   op = ALU_AND;
         I_OR:    op = ALU_OR;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/k_and_s_control_unit_if.sv
// Control <-> datapath bundle: decode + flags in, strobes out.
// master = control unit, slave = datapath.
interface k_and_s_control_unit_if;
   import k_and_s_pkg::*;

   decoded_instruction_type decoded_instruction;
   logic       zero_op;
   logic       neg_op;
   logic       unsigned_overflow;
   logic       signed_overflow;
   logic       branch;
   logic       pc_enable;
   logic       ir_enable;
   logic       addr_sel;
   logic       c_sel;
   logic [1:0] operation;
   logic       write_reg_enable;
   logic       flags_reg_enable;
   logic       ram_write_enable;
   logic       halt;

   modport master (
      input  decoded_instruction, zero_op, neg_op,
      input  unsigned_overflow, signed_overflow,
      output branch, pc_enable, ir_enable, addr_sel,
      output c_sel, operation, write_reg_enable,
      output flags_reg_enable, ram_write_enable, halt
   );

   modport slave (
      output decoded_instruction, zero_op, neg_op,
      output unsigned_overflow, signed_overflow,
      input  branch, pc_enable, ir_enable, addr_sel,
      input  c_sel, operation, write_reg_enable,
      input  flags_reg_enable, ram_write_enable, halt
   );

endinterface

// File: rtl/k_and_s_control_unit.sv
// K-and-S multi-cycle control FSM: fetch, decode, execute.
// Ports: clk, rst_n (async low), bus (master: decode/flags in, strobes out).
module k_and_s_control_unit
   import k_and_s_pkg::*;
#(
   parameter int unsigned LOAD_WAIT_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   k_and_s_control_unit_if.master  bus
);

   ctrl_state_t state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   flags_t      flags;

   assign flags = '{zero: bus.zero_op,
                    neg:  bus.neg_op,
                    uov:  bus.unsigned_overflow,
                    sov:  bus.signed_overflow};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.decoded_instruction)
               I_LOAD: begin
                  state_d = S_LOAD_ADDR;
                  // counter holds remaining extra wait cycles
                  cnt_d   = 3'(LOAD_WAIT_CYCLES - 1);
               end
               I_STORE:  state_d = S_STORE;
               I_MOVE:   state_d = S_MOVE;
               I_ADD, I_SUB, I_AND, I_OR:
                  state_d = S_ALU;
               I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
               I_BNNEG, I_BOV, I_BNOV:
                  state_d = S_BRANCH;
               I_HALT:   state_d = S_HALT;
               default:  state_d = S_NEXT;
            endcase
         end
         S_LOAD_ADDR: begin
            if (cnt_q == 3'd0) state_d = S_LOAD_WB;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_LOAD_WB, S_STORE, S_MOVE,
         S_ALU, S_BRANCH, S_NEXT:
            state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.branch           = 1'b0;
      bus.pc_enable        = 1'b0;
      bus.ir_enable        = 1'b0;
      bus.addr_sel         = 1'b0;
      bus.c_sel            = 1'b0;
      bus.operation        = ALU_ADD;
      bus.write_reg_enable = 1'b0;
      bus.flags_reg_enable = 1'b0;
      bus.ram_write_enable = 1'b0;
      bus.halt             = 1'b0;
      case (state_q)
         S_FETCH:     bus.ir_enable = 1'b1;
         S_LOAD_ADDR: bus.addr_sel  = 1'b1;
         S_LOAD_WB: begin
            bus.addr_sel         = 1'b1;
            bus.write_reg_enable = 1'b1;
            bus.pc_enable        = 1'b1;
         end
         S_STORE: begin
            bus.addr_sel         = 1'b1;
            bus.ram_write_enable = 1'b1;
            bus.pc_enable        = 1'b1;
         end
         S_MOVE: begin
            // both ALU inputs carry the source, so OR passes it through
            bus.c_sel            = 1'b1;
            bus.operation        = ALU_OR;
            bus.write_reg_enable = 1'b1;
            bus.pc_enable        = 1'b1;
         end
         S_ALU: begin
            bus.c_sel            = 1'b1;
            bus.operation        = alu_op(bus.decoded_instruction);
            bus.write_reg_enable = 1'b1;
            bus.flags_reg_enable = 1'b1;
            bus.pc_enable        = 1'b1;
         end
         S_BRANCH: begin
            bus.pc_enable = 1'b1;
            bus.branch    = branch_taken(bus.decoded_instruction, flags);
         end
         S_NEXT:  bus.pc_enable = 1'b1;
         S_HALT:  bus.halt      = 1'b1;
         default: ;
      endcase
   end

endmodule
